// File: rtl/elevator_pkg.sv
// Shared elevator types and sizing.
// Used by the call request unit and the controller.
package elevator_pkg;

    localparam int NUM_FLOORS = 5;
    localparam int FLOOR_W    = 3;
    localparam int DEB_CYCLES = 4;
    localparam int CNT_W      = 3;

    typedef logic [FLOOR_W-1:0]    floor_t;
    typedef logic [NUM_FLOORS-1:0] req_vec_t;
    typedef logic [CNT_W-1:0]      req_cnt_t;

    function automatic req_cnt_t popcount(input req_vec_t v);
        req_cnt_t n;
        n = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            n = n + req_cnt_t'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchroniser, debounce counter,
// and a single-cycle pulse on each debounced press.
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

    always_comb begin
        s1_d   = raw;
        s2_d   = s1_q;
        deb_d  = deb_q;
        cnt_d  = cnt_q;
        accept = 1'b0;
        if (s2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            accept = 1'b1;
            deb_d  = s2_q;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        // Releases are filtered the same way but never raise an event.
        press = accept && s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            deb_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/call_request_unit.sv
// Turns debounced hall/car presses into sticky floor calls,
// cleared when the car reports service of a floor.
module call_request_unit
    import elevator_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] raw_btn,
    input  logic                  svc_valid,
    input  logic [FLOOR_W-1:0]    svc_floor,
    output logic [NUM_FLOORS-1:0] req,
    output logic                  req_new,
    output logic [CNT_W-1:0]      req_count
);

    req_vec_t press;
    req_vec_t clr;
    req_vec_t req_q, req_d;
    logic     req_new_q, req_new_d;
    req_cnt_t req_count_q, req_count_d;

    for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_btn
        btn_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (raw_btn[f]),
            .press(press[f])
        );
    end

    always_comb begin
        clr = '0;
        // Out-of-range floor indices match no bit and are dropped.
        for (int f = 0; f < NUM_FLOORS; f++) begin
            clr[f] = svc_valid && (floor_t'(svc_floor) == floor_t'(f));
        end
        // A clear beats a coincident press: the stopped car serves it.
        req_d       = (req_q | press) & ~clr;
        req_new_d   = |(req_d & ~req_q);
        req_count_d = popcount(req_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q       <= '0;
            req_new_q   <= 1'b0;
            req_count_q <= '0;
        end else begin
            req_q       <= req_d;
            req_new_q   <= req_new_d;
            req_count_q <= req_count_d;
        end
    end

    assign req       = req_q;
    assign req_new   = req_new_q;
    assign req_count = req_count_q;

endmodule
